// File: rtl/proc_pkg.sv
// Shared instruction-format definitions for the issue unit and the processor decoder.
package proc_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned R1_W    = 5;
  localparam int unsigned R2_W    = 5;
  localparam int unsigned R3_W    = 3;
  localparam int unsigned IMM_W   = 16;

  localparam int unsigned OP_LSB  = 29;
  localparam int unsigned R1_LSB  = 24;
  localparam int unsigned R2_LSB  = 19;
  localparam int unsigned R3_LSB  = 16;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LW   = 3'b001;
  localparam logic [OP_W-1:0] OP_SW   = 3'b010;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } issue_state_t;

  function automatic logic [INST_W-1:0] pack_inst(
    input logic [OP_W-1:0]  op,
    input logic [R1_W-1:0]  r1,
    input logic [R2_W-1:0]  r2,
    input logic [R3_W-1:0]  r3,
    input logic [IMM_W-1:0] imm
  );
    return {op, r1, r2, r3, imm};
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: synchronous write, combinational read.
module prog_ram
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_issuer.sv
// Streams stored program words onto the 32-bit instruction bus with valid/stall
// handshaking, stopping at the program length or a HALT opcode.
module inst_issuer
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [OP_W-1:0]   load_op,
  input  logic [R1_W-1:0]   load_r1,
  input  logic [R2_W-1:0]   load_r2,
  input  logic [R3_W-1:0]   load_r3,
  input  logic [IMM_W-1:0]  load_imm,
  input  logic              start,
  input  logic [AW:0]       prog_len,
  input  logic              abort,
  input  logic              stall,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              busy,
  output logic              done
);

  issue_state_t      state;
  logic [AW:0]       pc;
  logic [AW:0]       len;
  logic [INST_W-1:0] rd_word;
  logic [AW:0]       len_clamp;
  logic              ram_we;
  logic              fetch;
  logic              xfer;
  logic              stop;

  // Program memory only accepts writes while the issuer is idle.
  assign ram_we = load_en && (state == ST_IDLE);

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_addr),
    .wdata (pack_inst(load_op, load_r1, load_r2, load_r3, load_imm)),
    .raddr (pc[AW-1:0]),
    .rdata (rd_word)
  );

  assign len_clamp = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign fetch     = !inst_valid || !stall;
  assign xfer      = inst_valid && !stall;
  // The length test wins, so an address past the program end is never acted upon.
  assign stop      = (pc == len) || (rd_word[OP_LSB +: OP_W] == OP_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      len        <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && (state != ST_IDLE)) begin
      state      <= ST_IDLE;
      inst_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state <= ST_RUN;
            pc    <= '0;
            len   <= len_clamp;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          // At a fetch point the presented word (if any) has just been taken.
          if (fetch) begin
            if (stop) begin
              state      <= ST_DRAIN;
              inst_valid <= 1'b0;
            end else begin
              inst       <= rd_word;
              inst_valid <= 1'b1;
              pc         <= pc + (AW+1)'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!inst_valid || xfer) begin
            inst_valid <= 1'b0;
            state      <= ST_DONE;
            done       <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_issuer.sv
// Randomized and directed bench for inst_issuer against a queue-based issue model.
module tb_inst_issuer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [2:0]    load_op;
  logic [4:0]    load_r1;
  logic [4:0]    load_r2;
  logic [2:0]    load_r3;
  logic [15:0]   load_imm;
  logic          start;
  logic [AW:0]   prog_len;
  logic          abort;
  logic          stall;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  inst_issuer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_op    (load_op),
    .load_r1    (load_r1),
    .load_r2    (load_r2),
    .load_r3    (load_r3),
    .load_imm   (load_imm),
    .start      (start),
    .prog_len   (prog_len),
    .abort      (abort),
    .stall      (stall),
    .inst       (inst),
    .inst_valid (inst_valid),
    .busy       (busy),
    .done       (done)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] got_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load_word(input int addr, input logic [2:0] op, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [2:0] r3, input logic [15:0] imm);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = AW'(addr);
    load_op   = op;
    load_r1   = r1;
    load_r2   = r2;
    load_r3   = r3;
    load_imm  = imm;
    @(posedge clk);
    #1 load_en = 1'b0;
    model_mem[addr] = {op, r1, r2, r3, imm};
  endtask

  // Runs one program; abort_cyc/ign_cyc < 0 disable the abort and ignored-input events.
  task automatic run_prog(input int len, input logic [31:0] stall_mask, input bit rnd,
                          input int abort_cyc, input int ign_cyc);
    logic [31:0] exp_q [$];
    logic [31:0] hold_word;
    int          n, n_exp, cyc, k;
    bit          seen_done, hold, aborted, timed;
    n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    for (int i = 0; i < n; i++) begin
      if (model_mem[i][31:29] == 3'b111) break;
      exp_q.push_back(model_mem[i]);
    end
    n_exp     = exp_q.size();
    timed     = !rnd && (stall_mask == 32'd0);
    got_q.delete();
    seen_done = 1'b0;
    hold      = 1'b0;
    aborted   = 1'b0;
    hold_word = '0;
    @(negedge clk);
    start    = 1'b1;
    prog_len = (AW+1)'(len);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 400 && !seen_done) begin
      @(negedge clk);
      if (aborted) begin
        check("abort_valid", 32'(inst_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        break;
      end
      if (cyc == 0) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_cycle0", 32'(inst_valid), 32'd0);
      end
      if (hold) begin
        check("hold_word", inst, hold_word);
        check("hold_valid", 32'(inst_valid), 32'd1);
      end
      if (done) begin
        seen_done = 1'b1;
        check("count_at_done", 32'(got_q.size()), 32'(n_exp));
        check("valid_at_done", 32'(inst_valid), 32'd0);
        check("busy_at_done", 32'(busy), 32'd1);
        if (timed) check("done_cycle", 32'(cyc), 32'(n_exp + 2));
      end else begin
        stall = rnd ? ($urandom_range(0, 2) == 0) : ((cyc < 32) ? stall_mask[cyc] : 1'b0);
        if (cyc == ign_cyc) begin
          start     = 1'b1;
          prog_len  = '0;
          load_en   = 1'b1;
          load_addr = '0;
          load_op   = 3'b111;
        end
        if (cyc == abort_cyc) begin
          abort   = 1'b1;
          stall   = 1'b1;
          aborted = 1'b1;
        end
        hold      = inst_valid && stall;
        hold_word = inst;
        if (inst_valid && !stall) begin
          k = got_q.size();
          if (k < n_exp) check("word", inst, exp_q[k]);
          if (timed) check("xfer_cycle", 32'(cyc), 32'(k + 1));
          got_q.push_back(inst);
        end
      end
      @(posedge clk);
      #1;
      start   = 1'b0;
      load_en = 1'b0;
      abort   = 1'b0;
      cyc++;
    end
    stall = 1'b0;
    if (!aborted) begin
      check("done_seen", 32'(seen_done), 32'd1);
      check("word_count", 32'(got_q.size()), 32'(n_exp));
      @(negedge clk);
      check("done_pulse_end", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int halt_seen;
    logic [2:0] op;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_op = '0; load_r1 = '0; load_r2 = '0;
    load_r3 = '0; load_imm = '0; start = 1'b0; prog_len = '0; abort = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inst", inst, 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) load_word(i, 3'd0, 5'd0, 5'd0, 3'd0, 16'd0);

    // Basic run and stall hold on the second word.
    load_word(0, 3'b001, 5'd2, 5'd0, 3'd0, 16'h0010);
    load_word(1, 3'b010, 5'd2, 5'd0, 3'd0, 16'h0020);
    load_word(2, 3'b000, 5'd0, 5'd0, 3'd0, 16'h0000);
    run_prog(3, 32'd0, 1'b0, -1, -1);
    check("basic_w0", got_at(0), 32'h2200_0010);
    check("basic_w1", got_at(1), 32'h4200_0020);
    check("basic_w2", got_at(2), 32'h0000_0000);
    run_prog(3, 32'h0000_003C, 1'b0, -1, -1);
    check("stall_w1", got_at(1), 32'h4200_0020);

    // HALT stops the stream and is never presented.
    load_word(1, 3'b111, 5'd0, 5'd0, 3'd0, 16'h0000);
    load_word(2, 3'b010, 5'd2, 5'd0, 3'd0, 16'h0020);
    run_prog(3, 32'd0, 1'b0, -1, -1);
    halt_seen = 0;
    foreach (got_q[i]) if (got_q[i][31:29] == 3'b111) halt_seen++;
    check("halt_not_issued", 32'(halt_seen), 32'd0);
    check("halt_w0", got_at(0), 32'h2200_0010);

    run_prog(0, 32'd0, 1'b0, -1, -1);

    // Full memory, oversize length.
    for (int i = 0; i < int'(DEPTH); i++)
      load_word(i, 3'($urandom_range(0, 6)), 5'($urandom), 5'($urandom), 3'($urandom), 16'($urandom));
    run_prog(int'(DEPTH) + 3, 32'd0, 1'b0, -1, -1);

    // Abort mid-stream, then a fresh run from address 0.
    run_prog(int'(DEPTH), 32'd0, 1'b0, 3, -1);
    run_prog(int'(DEPTH), 32'd0, 1'b0, -1, -1);

    // Reset mid-run keeps memory.
    @(negedge clk);
    start = 1'b1; prog_len = (AW+1)'(DEPTH);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("valid_before_rst", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_inst", inst, 32'd0);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    run_prog(int'(DEPTH), 32'd0, 1'b0, -1, -1);

    // start/load_en while busy are ignored; the next run sees unchanged memory.
    run_prog(int'(DEPTH), 32'd0, 1'b0, -1, 2);
    run_prog(int'(DEPTH), 32'd0, 1'b0, -1, -1);

    // Randomized programs, lengths and stall patterns.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        op = 3'($urandom_range(0, 6));
        if ($urandom_range(0, 9) == 0) op = 3'b111;
        load_word(i, op, 5'($urandom), 5'($urandom), 3'($urandom), 16'($urandom));
      end
      run_prog(int'($urandom_range(0, DEPTH + 3)), 32'd0, 1'b1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
